// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - register-file write-back arbiter: pipeline writes take priority,
// long-latency results wait in a 2-entry in-order queue and are killed by younger pipe writes.
module wb_arbiter #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pipe_we,
   input  logic [ADDR_W-1:0] pipe_waddr,
   input  logic [DATA_W-1:0] pipe_wdata,
   input  logic              div_valid,
   input  logic [ADDR_W-1:0] div_waddr,
   input  logic [DATA_W-1:0] div_wdata,
   output logic              div_ready,
   output logic              we,
   output logic [ADDR_W-1:0] waddr,
   output logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] chk_addr,
   output logic              chk_hit
);

   logic [1:0]        count, n_count;
   logic [ADDR_W-1:0] q_addr [2];
   logic [DATA_W-1:0] q_data [2];
   logic [ADDR_W-1:0] n_addr [2];
   logic [DATA_W-1:0] n_data [2];
   logic              n_we;
   logic [ADDR_W-1:0] n_waddr;
   logic [DATA_W-1:0] n_wdata;
   logic              pipe_eff, div_xfer, div_live, push;
   logic [1:0]        alive;

   assign pipe_eff  = pipe_we && (pipe_waddr != '0);
   assign div_ready = !rst && (count != 2'd2);
   assign div_xfer  = div_valid && div_ready;
   assign div_live  = div_xfer && (div_waddr != '0);

   // An entry survives this cycle unless an effective pipe write targets the same register.
   assign alive[0] = (count != 2'd0) && !(pipe_eff && (q_addr[0] == pipe_waddr));
   assign alive[1] = (count == 2'd2) && !(pipe_eff && (q_addr[1] == pipe_waddr));

   assign chk_hit = !rst && (chk_addr != '0) &&
                    ((alive[0] && (q_addr[0] == chk_addr)) ||
                     (alive[1] && (q_addr[1] == chk_addr)) ||
                     (div_xfer && (div_waddr == chk_addr)));

   always_comb begin
      n_count = count;
      n_addr  = q_addr;
      n_data  = q_data;
      n_we    = 1'b0;
      n_waddr = waddr;
      n_wdata = wdata;
      push    = 1'b0;
      if (pipe_eff) begin
         n_we    = 1'b1;
         n_waddr = pipe_waddr;
         n_wdata = pipe_wdata;
         if (alive[0]) begin
            n_count = alive[1] ? 2'd2 : 2'd1;
         end else if (alive[1]) begin
            n_addr[0] = q_addr[1];
            n_data[0] = q_data[1];
            n_count   = 2'd1;
         end else begin
            n_count = 2'd0;
         end
         push = div_live && (div_waddr != pipe_waddr);
      end else if (count != 2'd0) begin
         n_we      = 1'b1;
         n_waddr   = q_addr[0];
         n_wdata   = q_data[0];
         n_addr[0] = q_addr[1];
         n_data[0] = q_data[1];
         n_count   = count - 2'd1;
         push      = div_live;
      end else if (div_live) begin
         // Empty queue: forward the result straight to the write port.
         n_we    = 1'b1;
         n_waddr = div_waddr;
         n_wdata = div_wdata;
      end
      // div_ready guarantees at most one resident entry whenever a push lands here.
      if (push) begin
         if (n_count == 2'd0) begin
            n_addr[0] = div_waddr;
            n_data[0] = div_wdata;
         end else begin
            n_addr[1] = div_waddr;
            n_data[1] = div_wdata;
         end
         n_count = n_count + 2'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count     <= 2'd0;
         q_addr[0] <= '0;
         q_addr[1] <= '0;
         q_data[0] <= '0;
         q_data[1] <= '0;
         we        <= 1'b0;
         waddr     <= '0;
         wdata     <= '0;
      end else begin
         count  <= n_count;
         q_addr <= n_addr;
         q_data <= n_data;
         we     <= n_we;
         waddr  <= n_waddr;
         wdata  <= n_wdata;
      end
   end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - directed vector table plus randomized run against a queue-based model.
module tb_wb_arbiter;

   localparam int AW = 5;
   localparam int DW = 32;

   typedef struct {
      logic          rst;
      logic          pipe_we;
      logic [AW-1:0] pipe_waddr;
      logic [DW-1:0] pipe_wdata;
      logic          div_valid;
      logic [AW-1:0] div_waddr;
      logic [DW-1:0] div_wdata;
      logic [AW-1:0] chk_addr;
      logic          exp_ready;
      logic          exp_hit;
      logic          exp_we;
      logic [AW-1:0] exp_waddr;
      logic [DW-1:0] exp_wdata;
   } vec_t;

   typedef struct {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } ent_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          pipe_we;
   logic [AW-1:0] pipe_waddr;
   logic [DW-1:0] pipe_wdata;
   logic          div_valid;
   logic [AW-1:0] div_waddr;
   logic [DW-1:0] div_wdata;
   logic          div_ready;
   logic          we;
   logic [AW-1:0] waddr;
   logic [DW-1:0] wdata;
   logic [AW-1:0] chk_addr;
   logic          chk_hit;

   int checks = 0;
   int errors = 0;

   vec_t tbl[$];
   ent_t mq[$];
   logic          m_we = 1'b0;
   logic [AW-1:0] m_waddr = '0;
   logic [DW-1:0] m_wdata = '0;

   wb_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .clk(clk), .rst(rst),
      .pipe_we(pipe_we), .pipe_waddr(pipe_waddr), .pipe_wdata(pipe_wdata),
      .div_valid(div_valid), .div_waddr(div_waddr), .div_wdata(div_wdata),
      .div_ready(div_ready),
      .we(we), .waddr(waddr), .wdata(wdata),
      .chk_addr(chk_addr), .chk_hit(chk_hit)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int idx, input logic [DW-1:0] act,
                      input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s step %0d actual %0h expected %0h", name, idx, act, exp);
      end
   endtask

   task automatic add(input int r, input int pwe, input int pa, input int pd,
                      input int dv, input int da, input int dd, input int ca,
                      input int er, input int eh, input int ewe, input int ewa, input int ewd);
      vec_t v;
      v.rst = 1'(r);        v.pipe_we = 1'(pwe);   v.pipe_waddr = AW'(pa);
      v.pipe_wdata = DW'(pd); v.div_valid = 1'(dv); v.div_waddr = AW'(da);
      v.div_wdata = DW'(dd); v.chk_addr = AW'(ca);  v.exp_ready = 1'(er);
      v.exp_hit = 1'(eh);   v.exp_we = 1'(ewe);    v.exp_waddr = AW'(ewa);
      v.exp_wdata = DW'(ewd);
      tbl.push_back(v);
   endtask

   // Pre-edge view: readiness from occupancy, hit from queued-and-not-killed or in-flight.
   function automatic void model_comb(input vec_t v, output logic r, output logic h);
      logic peff;
      peff = v.pipe_we && (v.pipe_waddr != 0);
      r = !v.rst && (mq.size() < 2);
      h = 1'b0;
      if (!v.rst && v.chk_addr != 0) begin
         foreach (mq[i])
            if (mq[i].a == v.chk_addr && !(peff && mq[i].a == v.pipe_waddr)) h = 1'b1;
         if (v.div_valid && r && v.div_waddr == v.chk_addr) h = 1'b1;
      end
   endfunction

   task automatic model_edge(input vec_t v);
      logic rdy, peff, dlive;
      ent_t e;
      ent_t keep[$];
      rdy = !v.rst && (mq.size() < 2);
      if (v.rst) begin
         mq.delete();
         m_we = 1'b0; m_waddr = '0; m_wdata = '0;
         return;
      end
      peff  = v.pipe_we && (v.pipe_waddr != 0);
      dlive = v.div_valid && rdy && (v.div_waddr != 0);
      e.a = v.div_waddr;
      e.d = v.div_wdata;
      if (peff) begin
         foreach (mq[i]) if (mq[i].a != v.pipe_waddr) keep.push_back(mq[i]);
         mq = keep;
         if (dlive && v.div_waddr != v.pipe_waddr) mq.push_back(e);
         m_we = 1'b1; m_waddr = v.pipe_waddr; m_wdata = v.pipe_wdata;
      end else if (mq.size() > 0) begin
         m_we = 1'b1; m_waddr = mq[0].a; m_wdata = mq[0].d;
         mq.delete(0);
         if (dlive) mq.push_back(e);
      end else if (dlive) begin
         m_we = 1'b1; m_waddr = e.a; m_wdata = e.d;
      end else begin
         m_we = 1'b0;
      end
   endtask

   // Entered 1 time unit after a rising edge; leaves 1 time unit after the next one.
   task automatic do_cycle(input vec_t v, input bit use_model, input int idx);
      logic er, eh;
      rst = v.rst; pipe_we = v.pipe_we; pipe_waddr = v.pipe_waddr; pipe_wdata = v.pipe_wdata;
      div_valid = v.div_valid; div_waddr = v.div_waddr; div_wdata = v.div_wdata;
      chk_addr = v.chk_addr;
      @(negedge clk);
      if (use_model) model_comb(v, er, eh);
      else begin er = v.exp_ready; eh = v.exp_hit; end
      chk("div_ready", idx, DW'(div_ready), DW'(er));
      chk("chk_hit", idx, DW'(chk_hit), DW'(eh));
      @(posedge clk);
      model_edge(v);
      #1;
      if (use_model) begin
         chk("we", idx, DW'(we), DW'(m_we));
         chk("waddr", idx, DW'(waddr), DW'(m_waddr));
         chk("wdata", idx, wdata, m_wdata);
      end else begin
         chk("we", idx, DW'(we), DW'(v.exp_we));
         chk("waddr", idx, DW'(waddr), DW'(v.exp_waddr));
         chk("wdata", idx, wdata, v.exp_wdata);
      end
   endtask

   initial begin
      vec_t v;
      //  rst pwe pa pd      dv da dd     ca | rdy hit we wa wd
      add(1, 0, 0, 0,      0, 0, 0,     0,   0, 0, 0, 0, 0);
      add(1, 1, 4, 'h44,   1, 3, 'h33,  3,   0, 0, 0, 0, 0);
      add(0, 0, 0, 0,      1, 3, 'h11,  3,   1, 1, 1, 3, 'h11);
      add(0, 0, 0, 0,      0, 0, 0,     3,   1, 0, 0, 3, 'h11);
      add(0, 1, 4, 'hA,    1, 5, 'hB,   5,   1, 1, 1, 4, 'hA);
      add(0, 1, 4, 'hA,    1, 6, 'hC,   5,   1, 1, 1, 4, 'hA);
      add(0, 1, 4, 'hA,    1, 7, 'hD,   7,   0, 0, 1, 4, 'hA);
      add(0, 0, 0, 0,      0, 0, 0,     6,   0, 1, 1, 5, 'hB);
      add(0, 0, 0, 0,      0, 0, 0,     5,   1, 0, 1, 6, 'hC);
      add(0, 0, 0, 0,      0, 0, 0,     6,   1, 0, 0, 6, 'hC);
      add(0, 1, 1, 'h100,  1, 7, 'h1,   0,   1, 0, 1, 1, 'h100);
      add(0, 1, 1, 'h101,  1, 8, 'h2,   8,   1, 1, 1, 1, 'h101);
      add(0, 1, 7, 'h9,    0, 0, 0,     7,   0, 0, 1, 7, 'h9);
      add(0, 0, 0, 0,      0, 0, 0,     8,   1, 1, 1, 8, 'h2);
      add(0, 0, 0, 0,      0, 0, 0,     7,   1, 0, 0, 8, 'h2);
      add(0, 1, 1, 'h102,  1, 2, 'h5,   2,   1, 1, 1, 1, 'h102);
      add(0, 1, 0, 'hDEAD, 0, 0, 0,     2,   1, 1, 1, 2, 'h5);
      add(0, 0, 0, 0,      1, 0, 'h77,  0,   1, 0, 0, 2, 'h5);
      add(0, 1, 1, 'h103,  1, 10, 'hA0, 10,  1, 1, 1, 1, 'h103);
      add(0, 0, 0, 0,      1, 11, 'hB0, 10,  1, 1, 1, 10, 'hA0);
      add(0, 0, 0, 0,      1, 12, 'hC0, 11,  1, 1, 1, 11, 'hB0);
      add(0, 0, 0, 0,      0, 0, 0,     12,  1, 1, 1, 12, 'hC0);
      add(0, 1, 9, 'h99,   1, 9, 'h55,  9,   1, 1, 1, 9, 'h99);
      add(0, 0, 0, 0,      0, 0, 0,     9,   1, 0, 0, 9, 'h99);
      add(0, 1, 1, 'h104,  1, 13, 'hD,  0,   1, 0, 1, 1, 'h104);
      add(0, 1, 1, 'h105,  1, 14, 'hE,  13,  1, 1, 1, 1, 'h105);
      add(1, 1, 2, 'h22,   1, 15, 'hF,  13,  0, 0, 0, 0, 0);
      add(0, 0, 0, 0,      0, 0, 0,     13,  1, 0, 0, 0, 0);
      add(0, 0, 0, 0,      0, 0, 0,     14,  1, 0, 0, 0, 0);

      rst = 1'b1; pipe_we = 1'b0; pipe_waddr = '0; pipe_wdata = '0;
      div_valid = 1'b0; div_waddr = '0; div_wdata = '0; chk_addr = '0;
      @(posedge clk);
      #1;

      foreach (tbl[i]) do_cycle(tbl[i], 1'b0, i);

      v = tbl[0];
      do_cycle(v, 1'b1, 1000);
      for (int n = 0; n < 3000; n++) begin
         v.rst        = ($urandom_range(0, 63) == 0);
         v.pipe_we    = ($urandom_range(0, 1) == 1);
         v.pipe_waddr = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 3));
         v.pipe_wdata = $urandom;
         v.div_valid  = ($urandom_range(0, 9) < 6);
         v.div_waddr  = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 3));
         v.div_wdata  = $urandom;
         v.chk_addr   = AW'($urandom_range(0, 3));
         do_cycle(v, 1'b1, 2000 + n);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
